// File: rtl/dsp_pkg.sv
// Shared types and the rounding/saturating rescale helper for the DSP output path.
package dsp_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} router_state_e;

    // Fixed-width fields hold any practical source count and shift amount.
    typedef struct packed {
        logic       en;
        logic [7:0] sel;
        logic [7:0] shift;
    } router_cfg_t;

    typedef struct packed {
        logic        sat;
        logic [63:0] value;
    } sat_result_t;

    // Round-half-up arithmetic right shift, then clamp to a signed data_width range.
    // The sign-extended input must be at most 62 bits so the rounding add cannot overflow.
    function automatic sat_result_t sat_round(input logic signed [63:0] x,
                                              input logic [7:0]         shift,
                                              input int                 data_width);
        sat_result_t        res;
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r = x;
        if (shift != 8'd0)
            r = (x + (64'sd1 <<< (shift - 8'd1))) >>> shift;
        hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_width - 1));
        res.sat   = (r > hi) || (r < lo);
        res.value = (r > hi) ? hi : ((r < lo) ? lo : r);
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a combinational head read; push and pop may coincide at full or empty.
module sync_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         head,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || pop);
    // Gate the head so the output reads zero whenever nothing is buffered.
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/dsp_path_router.sv
// Selects one accumulator stream, rescales and saturates it, and buffers it toward dst;
// configuration changes wait for a full drain so configurations never mix.
module dsp_path_router
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 37,
    parameter int NUM_SRC     = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int SHIFT_WIDTH = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_valid,
    input  logic                          cfg_en,
    input  logic [$clog2(NUM_SRC)-1:0]    cfg_sel,
    input  logic [SHIFT_WIDTH-1:0]        cfg_shift,
    output logic                          cfg_busy,
    input  logic [NUM_SRC*ACC_WIDTH-1:0]  src_data,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic [DATA_WIDTH-1:0]         dst_data,
    output logic                          dst_valid,
    input  logic                          dst_ready,
    output logic                          sat_flag,
    input  logic                          sat_clr,
    output logic [31:0]                   sample_count
);
    router_state_e                 state;
    router_cfg_t                   cfg;
    router_cfg_t                   pending;
    router_cfg_t                   new_cfg;
    logic                          stage_valid;
    logic [DATA_WIDTH-1:0]         stage_data;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          run_ok;
    logic                          stage_ready;
    logic                          sel_valid;
    logic signed [ACC_WIDTH-1:0]   sel_data;
    logic                          accept;
    logic                          push;
    logic                          drained;
    sat_result_t                   res;
    logic                          unused_res;

    // NOTE: every always_comb output is assigned on every path so no latch is inferred.
    always_comb begin
        new_cfg.en  = cfg_en;
        new_cfg.sel = 8'(cfg_sel);
        if (int'(cfg_shift) > ACC_WIDTH - 1) new_cfg.shift = 8'(ACC_WIDTH - 1);
        else                                 new_cfg.shift = 8'(cfg_shift);
    end

    assign run_ok      = (state == RUN) && cfg.en;
    assign stage_ready = !stage_valid || !fifo_full;

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i == int'(cfg.sel)) begin
                sel_valid    = src_valid[i];
                sel_data     = src_data[i*ACC_WIDTH +: ACC_WIDTH];
                src_ready[i] = run_ok && stage_ready;
            end
        end
    end

    assign accept     = run_ok && stage_ready && sel_valid;
    assign res        = sat_round(64'(sel_data), cfg.shift, DATA_WIDTH);
    assign unused_res = ^res.value[63:DATA_WIDTH];
    assign push       = stage_valid && !fifo_full;
    assign drained    = !stage_valid && (fifo_count == '0);
    assign cfg_busy   = (state == DRAIN);
    assign dst_valid  = !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cfg          <= '0;
            pending      <= '0;
            stage_valid  <= 1'b0;
            stage_data   <= '0;
            sat_flag     <= 1'b0;
            sample_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        cfg   <= new_cfg;
                        state <= cfg_en ? RUN : IDLE;
                    end
                end
                RUN: begin
                    if (cfg_valid) begin
                        pending <= new_cfg;
                        state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        cfg   <= pending;
                        state <= pending.en ? RUN : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                stage_valid <= 1'b1;
                stage_data  <= res.value[DATA_WIDTH-1:0];
            end else if (push) begin
                stage_valid <= 1'b0;
            end

            // A saturating accept outranks a simultaneous clear.
            if (accept && res.sat) sat_flag <= 1'b1;
            else if (sat_clr)      sat_flag <= 1'b0;

            if (dst_valid && dst_ready) sample_count <= sample_count + 32'd1;
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (stage_data),
        .pop       (dst_ready),
        .head      (dst_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_dsp_path_router.sv
// Directed bench for dsp_path_router: an input-side monitor pushes model results into a
// scoreboard queue, an output-side monitor pops and compares on every dst handshake.
module tb_dsp_path_router;
    localparam int DW = 16;
    localparam int AW = 37;
    localparam int NS = 4;
    localparam int FD = 4;
    localparam int SW = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_valid = 1'b0;
    logic              cfg_en = 1'b0;
    logic [1:0]        cfg_sel = '0;
    logic [SW-1:0]     cfg_shift = '0;
    logic              cfg_busy;
    logic [NS*AW-1:0]  src_data = '0;
    logic [NS-1:0]     src_valid = '0;
    logic [NS-1:0]     src_ready;
    logic [DW-1:0]     dst_data;
    logic              dst_valid;
    logic              dst_ready = 1'b1;
    logic              sat_flag;
    logic              sat_clr = 1'b0;
    logic [31:0]       sample_count;

    always #5 clk = ~clk;

    dsp_path_router #(
        .DATA_WIDTH (DW), .ACC_WIDTH (AW), .NUM_SRC (NS),
        .FIFO_DEPTH (FD), .SHIFT_WIDTH (SW)
    ) dut (
        .clk (clk), .rst (rst),
        .cfg_valid (cfg_valid), .cfg_en (cfg_en), .cfg_sel (cfg_sel),
        .cfg_shift (cfg_shift), .cfg_busy (cfg_busy),
        .src_data (src_data), .src_valid (src_valid), .src_ready (src_ready),
        .dst_data (dst_data), .dst_valid (dst_valid), .dst_ready (dst_ready),
        .sat_flag (sat_flag), .sat_clr (sat_clr), .sample_count (sample_count)
    );

    logic [DW-1:0] sb [$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            n_pushed = 0;
    int            m_shift  = 0;
    int            n_acc;
    logic [DW:0]   mv;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference rescale: floor division by 2^s after adding half, then clamp.
    function automatic logic [DW:0] model(input logic [AW-1:0] d, input int s);
        longint x, r, p;
        int     sh;
        x  = longint'($signed(d));
        sh = (s > AW - 1) ? AW - 1 : s;
        if (sh == 0) begin
            r = x;
        end else begin
            p = longint'(1) << sh;
            r = x + p / 2;
            if (r >= 0) r = r / p;
            else        r = -((-r + p - 1) / p);
        end
        if (r > 32767)  return {1'b1, 16'h7fff};
        if (r < -32768) return {1'b1, 16'h8000};
        return {1'b0, r[15:0]};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (dst_valid && dst_ready) begin
                check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) check("dst_data", 64'(dst_data), 64'(sb.pop_front()));
            end
            for (int k = 0; k < NS; k++) begin
                if (src_valid[k] && src_ready[k]) begin
                    mv = model(src_data[k*AW +: AW], m_shift);
                    sb.push_back(mv[DW-1:0]);
                    n_pushed++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic configure(input logic en, input int sel, input int shift);
        cfg_valid = 1'b1;
        cfg_en    = en;
        cfg_sel   = 2'(sel);
        cfg_shift = SW'(shift);
        tick();
        cfg_valid = 1'b0;
        for (int i = 0; i < 100 && cfg_busy; i++) tick();
        check("cfg_settle", 64'(cfg_busy), 64'd0);
        m_shift = shift;
    endtask

    task automatic send(input int s, input logic [AW-1:0] d);
        src_data[s*AW +: AW] = d;
        src_valid            = '0;
        src_valid[s]         = 1'b1;
        #1;
        for (int i = 0; i < 50 && !src_ready[s]; i++) tick();
        check("send_ready", 64'(src_ready[s]), 64'd1);
        tick();
        src_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wait_cycles(3);
        rst = 1'b0;
        #1;
        check("rst_src_ready", 64'(src_ready), 64'd0);
        check("rst_dst_valid", 64'(dst_valid), 64'd0);
        check("rst_dst_data", 64'(dst_data), 64'd0);
        check("rst_cfg_busy", 64'(cfg_busy), 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check("rst_sample_count", 64'(sample_count), 64'd0);

        // Basic route with two-cycle latency
        configure(1'b1, 2, 4);
        src_data[2*AW +: AW] = 37'h000000130;
        src_valid = 4'b0100;
        #1;
        check("basic_src_ready", 64'(src_ready), 64'h4);
        tick();
        src_valid = '0;
        check("basic_lat1_valid", 64'(dst_valid), 64'd0);
        tick();
        check("basic_lat2_valid", 64'(dst_valid), 64'd1);
        check("basic_lat2_data", 64'(dst_data), 64'h13);
        check("basic_unsel_ready", 64'(src_ready & 4'b1011), 64'd0);
        tick();
        check("basic_count", 64'(sample_count), 64'd1);

        // Rounding, shift clamp and saturation
        configure(1'b1, 2, 1);
        send(2, 37'd3);
        send(2, 37'(-3));
        configure(1'b1, 2, 50);
        send(2, 37'h1000000000);
        configure(1'b1, 2, 0);
        check("sat_before", 64'(sat_flag), 64'd0);
        send(2, 37'd40000);
        check("sat_set", 64'(sat_flag), 64'd1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        check("sat_cleared", 64'(sat_flag), 64'd0);
        sat_clr = 1'b1;
        send(2, 37'(-40000));
        sat_clr = 1'b0;
        check("sat_set_wins", 64'(sat_flag), 64'd1);
        wait_cycles(5);
        check("round_count", 64'(sample_count), 64'(n_pushed));

        // Backpressure: 4 FIFO entries plus the stage register
        dst_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 8; c++) begin
            src_data[2*AW +: AW] = AW'(100 + n_acc);
            src_valid = 4'b0100;
            #1;
            if (src_ready[2]) n_acc++;
            tick();
        end
        check("bp_accepted", 64'(n_acc), 64'd5);
        check("bp_ready_low", 64'(src_ready), 64'd0);
        dst_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            src_data[2*AW +: AW] = AW'(100 + n_acc);
            #1;
            if (src_ready[2]) n_acc++;
            tick();
        end
        src_valid = '0;
        wait_cycles(6);
        check("bp_all_out", 64'(sample_count), 64'(n_pushed));

        // Reconfiguration waits for a clean drain
        dst_ready = 1'b0;
        send(2, 37'd11);
        send(2, 37'd22);
        send(2, 37'd33);
        wait_cycles(2);
        cfg_valid = 1'b1; cfg_en = 1'b1; cfg_sel = 2'd1; cfg_shift = '0;
        tick();
        cfg_valid = 1'b0;
        check("drain_busy", 64'(cfg_busy), 64'd1);
        check("drain_ready_low", 64'(src_ready), 64'd0);
        wait_cycles(3);
        check("drain_busy_stall", 64'(cfg_busy), 64'd1);
        dst_ready = 1'b1;
        for (int i = 0; i < 20 && dst_valid; i++) tick();
        check("drain_empty", 64'(dst_valid), 64'd0);
        check("drain_busy_at_empty", 64'(cfg_busy), 64'd1);
        tick();
        check("drain_switched", 64'(cfg_busy), 64'd0);
        check("drain_new_ready", 64'(src_ready), 64'h2);
        m_shift = 0;
        send(1, 37'd77);
        wait_cycles(4);
        check("drain_count", 64'(sample_count), 64'(n_pushed));

        // Disable while data is buffered
        dst_ready = 1'b0;
        send(1, 37'd5);
        send(1, 37'd6);
        tick();
        cfg_valid = 1'b1; cfg_en = 1'b0; cfg_sel = 2'd1;
        tick();
        cfg_valid = 1'b0;
        check("dis_busy", 64'(cfg_busy), 64'd1);
        dst_ready = 1'b1;
        for (int i = 0; i < 50 && cfg_busy; i++) tick();
        check("dis_idle", 64'(cfg_busy), 64'd0);
        src_valid = 4'b0010;
        #1;
        check("dis_ready_low", 64'(src_ready), 64'd0);
        tick();
        check("dis_ready_stays_low", 64'(src_ready), 64'd0);
        src_valid = '0;
        check("dis_delivered", 64'(sample_count), 64'(n_pushed));
        check("dis_sb_empty", 64'(sb.size()), 64'd0);

        // Reset with a full FIFO
        configure(1'b1, 0, 0);
        dst_ready = 1'b0;
        src_valid = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            src_data[0 +: AW] = (c == 0) ? 37'd40000 : AW'(c);
            tick();
        end
        src_valid = '0;
        check("full_ready_low", 64'(src_ready), 64'd0);
        check("full_sat", 64'(sat_flag), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_dst_valid", 64'(dst_valid), 64'd0);
        check("mid_rst_dst_data", 64'(dst_data), 64'd0);
        check("mid_rst_count", 64'(sample_count), 64'd0);
        check("mid_rst_sat", 64'(sat_flag), 64'd0);
        check("mid_rst_ready", 64'(src_ready), 64'd0);
        check("mid_rst_busy", 64'(cfg_busy), 64'd0);
        n_pushed = 0;
        dst_ready = 1'b1;
        configure(1'b1, 3, 0);
        send(3, 37'(-5));
        wait_cycles(4);
        check("post_rst_count", 64'(sample_count), 64'(n_pushed));
        check("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
